// File: rtl/fp_int_mul_vec.sv
// FP16 activation x LANES bit-serial two's complement weights, one product per lane.
// Ports: clk, rst (async, active-high); act/w/valid/w_ready for the weight beats (LSB first);
//        set/precision load the per-word weight width (IDLE only);
//        sign_out/exp_out/mantissa_out/start_acc/acc_ready carry the result downstream.
// Macro FP_INT_MUL_SUBNORM_EN: defined -> exp==0 uses significand {0,frac};
//        undefined -> exp==0 flushes the activation to zero.
module fp_int_mul_vec #(
  parameter int LANES    = 4,
  parameter int MAX_PREC = 8,
  parameter int MANT_W   = 11 + MAX_PREC
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [15:0]             act,
  input  logic [LANES-1:0]        w,
  input  logic                    valid,
  output logic                    w_ready,
  input  logic                    set,
  input  logic [3:0]              precision,
  output logic [LANES-1:0]        sign_out,
  output logic [4:0]              exp_out,
  output logic [LANES*MANT_W-1:0] mantissa_out,
  output logic                    start_acc,
  input  logic                    acc_ready
);

  // One guard bit so the MSB beat can drive the sum negative.
  localparam int AW = MANT_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } state_t;

  state_t                   state_q, state_d;
  logic [3:0]               prec_q, prec_d;
  logic [3:0]               cnt_q, cnt_d;
  logic                     asign_q, asign_d;
  logic [4:0]               aexp_q, aexp_d;
  logic [10:0]              sig_q, sig_d;
  logic signed [AW-1:0]     acc_q [LANES];
  logic signed [AW-1:0]     acc_d [LANES];
  logic [LANES-1:0]         sign_q, sign_d;
  logic [4:0]               exp_q, exp_d;
  logic [LANES*MANT_W-1:0]  mant_q, mant_d;
  logic                     start_q, start_d;

  logic [10:0]              act_sig;
  logic [10:0]              beat_sig;
  logic signed [AW-1:0]     term;
  logic [MANT_W-1:0]        mag;
  logic                     last;

  function automatic logic [3:0] clamp_prec(input logic [3:0] p);
    if (p < 4'd2) return 4'd2;
    if (p > 4'(MAX_PREC)) return 4'(MAX_PREC);
    return p;
  endfunction

  always_comb begin
    if (act[14:10] != 5'd0) begin
      act_sig = {1'b1, act[9:0]};
    end else begin
`ifdef FP_INT_MUL_SUBNORM_EN
      act_sig = {1'b0, act[9:0]};
`else
      act_sig = 11'd0;
`endif
    end
  end

  assign w_ready = (state_q != HOLD);
  assign last    = (cnt_q == prec_q - 4'd1);

  always_comb begin
    state_d  = state_q;
    prec_d   = prec_q;
    cnt_d    = cnt_q;
    asign_d  = asign_q;
    aexp_d   = aexp_q;
    sig_d    = sig_q;
    acc_d    = acc_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mant_d   = mant_q;
    start_d  = start_q;
    beat_sig = sig_q;
    term     = '0;
    mag      = '0;

    unique case (state_q)
      IDLE: begin
        if (set) prec_d = clamp_prec(precision);
        if (valid) begin
          // First beat: the activation is captured and used immediately.
          asign_d  = act[15];
          aexp_d   = act[14:10];
          sig_d    = act_sig;
          beat_sig = act_sig;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (valid && last) state_d = HOLD;
      end
      HOLD: begin
        if (!start_q) begin
          for (int l = 0; l < LANES; l++) begin
            mag = acc_q[l][AW-1] ? MANT_W'(-acc_q[l])
                                 : acc_q[l][MANT_W-1:0];
            mant_d[l*MANT_W +: MANT_W] = mag;
            sign_d[l] = (acc_q[l] != '0) &
                        (asign_q ^ acc_q[l][AW-1]);
          end
          exp_d   = aexp_q;
          start_d = 1'b1;
        end else if (acc_ready) begin
          start_d = 1'b0;
          state_d = IDLE;
          cnt_d   = '0;
          for (int l = 0; l < LANES; l++) acc_d[l] = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (valid && state_q != HOLD) begin
      term = $signed({{(AW-11){1'b0}}, beat_sig}) <<< cnt_q;
      for (int l = 0; l < LANES; l++) begin
        if (w[l]) acc_d[l] = last ? acc_q[l] - term : acc_q[l] + term;
      end
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      prec_q  <= 4'(MAX_PREC);
      cnt_q   <= '0;
      asign_q <= 1'b0;
      aexp_q  <= '0;
      sig_q   <= '0;
      for (int l = 0; l < LANES; l++) acc_q[l] <= '0;
      sign_q  <= '0;
      exp_q   <= '0;
      mant_q  <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prec_q  <= prec_d;
      cnt_q   <= cnt_d;
      asign_q <= asign_d;
      aexp_q  <= aexp_d;
      sig_q   <= sig_d;
      acc_q   <= acc_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      mant_q  <= mant_d;
      start_q <= start_d;
    end
  end

  assign sign_out     = sign_q;
  assign exp_out      = exp_q;
  assign mantissa_out = mant_q;
  assign start_acc    = start_q;

endmodule

// File: tb/tb_fp_int_mul_vec.sv
// Self-checking bench for fp_int_mul_vec.
// Expected products come from a plain-integer reference model.
module tb_fp_int_mul_vec;
  localparam int LANES    = 4;
  localparam int MAX_PREC = 8;
  localparam int MANT_W   = 11 + MAX_PREC;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [15:0]             act;
  logic [LANES-1:0]        w;
  logic                    valid;
  logic                    w_ready;
  logic                    set;
  logic [3:0]              precision;
  logic [LANES-1:0]        sign_out;
  logic [4:0]              exp_out;
  logic [LANES*MANT_W-1:0] mantissa_out;
  logic                    start_acc;
  logic                    acc_ready;

  int total = 0;
  int bad   = 0;
  int mprec = MAX_PREC;

  logic [LANES-1:0]        e_sign;
  logic [4:0]              e_exp;
  logic [LANES*MANT_W-1:0] e_mant;

  always #5 clk = ~clk;

  fp_int_mul_vec #(.LANES(LANES), .MAX_PREC(MAX_PREC)) dut (
    .clk(clk), .rst(rst), .act(act), .w(w), .valid(valid),
    .w_ready(w_ready), .set(set), .precision(precision),
    .sign_out(sign_out), .exp_out(exp_out),
    .mantissa_out(mantissa_out), .start_acc(start_acc),
    .acc_ready(acc_ready)
  );

  function automatic int model_sig(input logic [15:0] a);
    if (a[14:10] != 5'd0) return 1024 + int'(a[9:0]);
`ifdef FP_INT_MUL_SUBNORM_EN
    return int'(a[9:0]);
`else
    return 0;
`endif
  endfunction

  function automatic int clampp(input int p);
    if (p < 2) return 2;
    if (p > MAX_PREC) return MAX_PREC;
    return p;
  endfunction

  function automatic int rand_w(input int p);
    return int'($urandom_range(0, (1 << p) - 1)) - (1 << (p - 1));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_prec(input int p);
    set = 1'b1;
    precision = 4'(p);
    step();
    set = 1'b0;
    mprec = clampp(p);
  endtask

  // Drive one word, check latency and result. Leaves handshake pending if !ack.
  task automatic run_word(input logic [15:0] a, input int wv[LANES],
                          input int stall_at, input int stall_len,
                          input bit set_mid, input bit ack,
                          input string tag);
    int s, lat, cyc, want;
    longint prod, mg;
    s = model_sig(a);
    e_exp = a[14:10];
    e_sign = '0;
    e_mant = '0;
    for (int l = 0; l < LANES; l++) begin
      prod = longint'(s) * longint'(wv[l]);
      mg = (prod < 0) ? -prod : prod;
      e_sign[l] = (prod != 0) && (a[15] ^ (prod < 0));
      e_mant[l*MANT_W +: MANT_W] = MANT_W'(mg);
    end
    want = mprec + 1 + ((stall_at >= 0) ? stall_len : 0);
    lat = -1;
    cyc = 0;
    for (int i = 0; i < mprec; i++) begin
      if (i == stall_at) begin
        for (int j = 0; j < stall_len; j++) begin
          valid = 1'b0;
          w = 4'($urandom);
          step();
          cyc++;
          if (start_acc && lat < 0) lat = cyc;
        end
      end
      valid = 1'b1;
      act = (i == 0) ? a : 16'($urandom);
      for (int l = 0; l < LANES; l++) w[l] = wv[l][i];
      set = set_mid && (i == 1);
      precision = 4'd3;
      step();
      cyc++;
      if (start_acc && lat < 0) lat = cyc;
    end
    valid = 1'b0;
    set = 1'b0;
    while (lat < 0 && cyc < 40) begin
      step();
      cyc++;
      if (start_acc) lat = cyc;
    end
    total++;
    if (lat != want) begin
      bad++;
      $display("FAIL %s latency: got %0d want %0d", tag, lat, want);
    end
    if (lat < 0) return;
    total++;
    if (sign_out !== e_sign) begin
      bad++;
      $display("FAIL %s sign: got %b want %b", tag, sign_out, e_sign);
    end
    total++;
    if (exp_out !== e_exp) begin
      bad++;
      $display("FAIL %s exp: got %0d want %0d", tag, exp_out, e_exp);
    end
    total++;
    if (mantissa_out !== e_mant) begin
      bad++;
      $display("FAIL %s mant: got %h want %h", tag, mantissa_out, e_mant);
    end
    if (ack) begin
      acc_ready = 1'b1;
      step();
      acc_ready = 1'b0;
      total++;
      if (start_acc !== 1'b0 || w_ready !== 1'b1) begin
        bad++;
        $display("FAIL %s ack: start=%b ready=%b want 0 1",
                 tag, start_acc, w_ready);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    act = '0; w = '0; valid = 1'b0; set = 1'b0;
    precision = '0; acc_ready = 1'b0;
    step();
    step();
    total++;
    if (start_acc !== 1'b0 || sign_out !== '0 || exp_out !== '0 ||
        mantissa_out !== '0 || w_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset: start=%b sign=%b exp=%0d mant=%h ready=%b want zeros ready=1",
               start_acc, sign_out, exp_out, mantissa_out, w_ready);
    end
    rst = 1'b0;
    step();
    mprec = MAX_PREC;
  endtask

  task automatic test_default_prec();
    int wv[LANES];
    for (int l = 0; l < LANES; l++) wv[l] = rand_w(MAX_PREC);
    run_word(16'h4500, wv, -1, 0, 1'b0, 1'b1, "default_prec");
  endtask

  task automatic test_basic();
    int wv[LANES];
    wv = '{3, -8, 0, 7};
    set_prec(4);
    run_word(16'h3C00, wv, -1, 0, 1'b0, 1'b1, "basic");
  endtask

  task automatic test_stall();
    int wv[LANES];
    wv = '{3, -8, 0, 7};
    run_word(16'hBC00, wv, 2, 3, 1'b0, 1'b1, "stall");
  endtask

  task automatic test_backpressure();
    int wv[LANES];
    for (int l = 0; l < LANES; l++) wv[l] = rand_w(mprec);
    run_word(16'h5A3F, wv, -1, 0, 1'b0, 1'b0, "bp_word");
    for (int k = 0; k < 5; k++) begin
      valid = 1'b1;
      w = 4'($urandom);
      act = 16'($urandom);
      step();
      total++;
      if (start_acc !== 1'b1 || w_ready !== 1'b0 || sign_out !== e_sign ||
          exp_out !== e_exp || mantissa_out !== e_mant) begin
        bad++;
        $display("FAIL bp_hold cyc%0d: start=%b ready=%b sign=%b mant=%h want 1 0 %b %h",
                 k, start_acc, w_ready, sign_out, mantissa_out, e_sign, e_mant);
      end
    end
    valid = 1'b0;
    acc_ready = 1'b1;
    step();
    acc_ready = 1'b0;
    total++;
    if (start_acc !== 1'b0 || w_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: start=%b ready=%b want 0 1", start_acc, w_ready);
    end
    for (int l = 0; l < LANES; l++) wv[l] = rand_w(mprec);
    run_word(16'hC123, wv, -1, 0, 1'b0, 1'b1, "bp_after");
  endtask

  task automatic test_precision();
    int wv[LANES];
    set_prec(1);
    for (int l = 0; l < LANES; l++) wv[l] = rand_w(mprec);
    run_word(16'h3E00, wv, -1, 0, 1'b0, 1'b1, "prec1");
    set_prec(12);
    for (int l = 0; l < LANES; l++) wv[l] = rand_w(mprec);
    run_word(16'hB800, wv, -1, 0, 1'b1, 1'b1, "prec12_setmid");
    for (int l = 0; l < LANES; l++) wv[l] = rand_w(mprec);
    run_word(16'h4248, wv, -1, 0, 1'b0, 1'b1, "prec12_again");
  endtask

  task automatic test_subnorm();
    int wv[LANES];
    wv = '{1, 0, 0, 0};
    set_prec(2);
    run_word(16'h0200, wv, -1, 0, 1'b0, 1'b1, "subnorm");
  endtask

  task automatic test_random();
    int wv[LANES];
    int st;
    for (int n = 0; n < 12; n++) begin
      set_prec(int'($urandom_range(0, 15)));
      for (int l = 0; l < LANES; l++) wv[l] = rand_w(mprec);
      st = (n % 3 == 0) ? int'($urandom_range(1, mprec - 1)) : -1;
      run_word(16'($urandom), wv, st, int'($urandom_range(1, 4)),
               1'b0, 1'b1, "random");
    end
  endtask

  task automatic test_reset_mid();
    int wv[LANES];
    int seen;
    set_prec(3);
    for (int i = 0; i < 2; i++) begin
      valid = 1'b1;
      act = 16'h3C00;
      w = 4'hF;
      step();
    end
    valid = 1'b0;
    rst = 1'b1;
    #2;
    total++;
    if (start_acc !== 1'b0 || mantissa_out !== '0 || sign_out !== '0 ||
        exp_out !== '0 || w_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_shift: start=%b mant=%h sign=%b exp=%0d ready=%b want zeros 1",
               start_acc, mantissa_out, sign_out, exp_out, w_ready);
    end
    rst = 1'b0;
    mprec = MAX_PREC;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (start_acc) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL rst_shift_quiet: start_acc seen %0d want 0", seen);
    end
    for (int l = 0; l < LANES; l++) wv[l] = rand_w(mprec);
    run_word(16'h4400, wv, -1, 0, 1'b0, 1'b0, "rst_hold_word");
    rst = 1'b1;
    #2;
    total++;
    if (start_acc !== 1'b0 || mantissa_out !== '0 || sign_out !== '0 ||
        exp_out !== '0 || w_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_hold: start=%b mant=%h sign=%b exp=%0d ready=%b want zeros 1",
               start_acc, mantissa_out, sign_out, exp_out, w_ready);
    end
    rst = 1'b0;
    acc_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (start_acc) seen++;
    end
    acc_ready = 1'b0;
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL rst_hold_quiet: start_acc seen %0d want 0", seen);
    end
    for (int l = 0; l < LANES; l++) wv[l] = rand_w(mprec);
    run_word(16'hC7FF, wv, -1, 0, 1'b0, 1'b1, "rst_new_word");
  endtask

  initial begin
    test_reset();
    test_default_prec();
    test_basic();
    test_stall();
    test_backpressure();
    test_precision();
    test_subnorm();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
